// File: rtl/sm_uart_loader_pkg.sv
// sm_uart_loader_pkg: shared header byte and state encodings for the UART loader
package sm_uart_loader_pkg;
  localparam logic [7:0] HEADER = 8'hA5;
  typedef enum logic [1:0] {IDLE, CNT, DATA, CSUM} loadState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
endpackage

// File: rtl/sm_uart_rx.sv
// sm_uart_rx: synchronised 8N1 receiver producing one-cycle byteValid / frameErr strobes
module sm_uart_rx import sm_uart_loader_pkg::*; #(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byteValid,
  output logic       frameErr,
  output logic [7:0] byteData
);
  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  logic s1, s2, prev;
  rxState_t state, stateNext;
  logic [15:0] cnt, cntNext;
  logic [2:0] bitIdx, bitNext;
  logic [7:0] shift, shiftNext;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
      state <= RX_IDLE;
      cnt <= '0;
      bitIdx <= '0;
      shift <= '0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      prev <= s2;
      state <= stateNext;
      cnt <= cntNext;
      bitIdx <= bitNext;
      shift <= shiftNext;
    end
  end
  always_comb begin
    stateNext = state;
    cntNext = cnt + 16'd1;
    bitNext = bitIdx;
    shiftNext = shift;
    byteValid = 1'b0;
    frameErr = 1'b0;
    case (state)
      RX_IDLE: begin
        cntNext = '0;
        stateNext = prev && !s2 ? RX_START : RX_IDLE;
      end
      RX_START: if (cnt == HALF_LAST) begin
        cntNext = '0;
        bitNext = '0;
        stateNext = s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == LAST) begin
        cntNext = '0;
        shiftNext = {s2, shift[7:1]};
        bitNext = bitIdx + 3'd1;
        stateNext = bitIdx == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (cnt == LAST) begin
        cntNext = '0;
        stateNext = RX_IDLE;
        byteValid = s2;
        frameErr = !s2;
      end
      default: stateNext = RX_IDLE;
    endcase
  end
  assign byteData = shift;
endmodule

// File: rtl/sm_uart_loader.sv
// sm_uart_loader: UART boot loader writing framed words into instruction memory and holding the CPU in reset
module sm_uart_loader import sm_uart_loader_pkg::*; #(
  parameter int BAUD_DIV = 16,
  parameter int ADDR_W = 6,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              imWe,
  output logic [ADDR_W-1:0] imAddr,
  output logic [31:0]       imWData,
  output logic              cpuRst_n,
  output logic              busy,
  output logic              err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int MAX_N = 1 << ADDR_W;
  logic byteValid, frameErr;
  logic [7:0] byteData;
  loadState_t state, stateNext;
  logic [7:0] wordsLeft, csum;
  logic [1:0] byteIdx;
  logic [23:0] wordBuf;
  logic [TW-1:0] timer;
  logic hold, accept, wordDone, success, fail, timedOut;
  sm_uart_rx #(.BAUD_DIV(BAUD_DIV)) uRx (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .byteValid(byteValid), .frameErr(frameErr), .byteData(byteData)
  );
  assign busy = state != IDLE;
  assign timedOut = !byteValid && timer == TW'(TIMEOUT);
  always_comb begin
    stateNext = state;
    accept = 1'b0;
    wordDone = 1'b0;
    success = 1'b0;
    fail = 1'b0;
    if (busy && (frameErr || timedOut)) begin
      fail = 1'b1;
      stateNext = IDLE;
    end else if (byteValid) begin
      case (state)
        IDLE: begin
          accept = byteData == HEADER;
          stateNext = accept ? CNT : IDLE;
        end
        CNT: begin
          fail = byteData == 8'd0 || int'(byteData) > MAX_N;
          stateNext = fail ? IDLE : DATA;
        end
        DATA: begin
          wordDone = byteIdx == 2'd3;
          stateNext = wordDone && wordsLeft == 8'd1 ? CSUM : DATA;
        end
        CSUM: begin
          success = byteData == csum;
          fail = !success;
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      imWe <= 1'b0;
      imAddr <= '0;
      imWData <= '0;
      cpuRst_n <= 1'b0;
      err <= 1'b0;
      hold <= 1'b0;
      wordsLeft <= '0;
      csum <= '0;
      byteIdx <= '0;
      wordBuf <= '0;
      timer <= '0;
    end else begin
      state <= stateNext;
      imWe <= wordDone;
      hold <= accept | (hold & ~success);
      cpuRst_n <= ~(accept | (hold & ~success));
      err <= fail | (err & ~success);
      timer <= byteValid || !busy ? '0 : timer == TW'(TIMEOUT) ? timer : timer + TW'(1);
      if (accept) begin
        imAddr <= '0;
        csum <= '0;
        byteIdx <= '0;
      end else if (imWe) imAddr <= imAddr + ADDR_W'(1);
      if (byteValid && state == CNT) wordsLeft <= byteData;
      if (byteValid && state == DATA) begin
        csum <= csum + byteData;
        byteIdx <= byteIdx + 2'd1;
        wordBuf <= {byteData, wordBuf[23:8]};
      end
      if (wordDone) begin
        imWData <= {byteData, wordBuf};
        wordsLeft <= wordsLeft - 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_sm_uart_loader.sv
// tb_sm_uart_loader: randomized frame-level bench against a byte-list reference model
module tb_sm_uart_loader;
  localparam int BAUD_DIV = 4;
  localparam int ADDR_W = 6;
  localparam int TIMEOUT = 200;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic imWe, cpuRst_n, busy, err;
  logic [ADDR_W-1:0] imAddr;
  logic [31:0] imWData;
  int passed = 0, total = 0;
  logic [7:0] fr[$];
  logic [ADDR_W-1:0] expA[$], gotA[$];
  logic [31:0] expD[$], gotD[$];
  bit expErr;
  sm_uart_loader #(.BAUD_DIV(BAUD_DIV), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .imWe(imWe), .imAddr(imAddr),
    .imWData(imWData), .cpuRst_n(cpuRst_n), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && imWe) begin
    gotA.push_back(imAddr);
    gotD.push_back(imWData);
  end
  task automatic do_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gotA.delete();
    gotD.delete();
  endtask
  task automatic send_byte(input logic [7:0] b, input bit badStop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    rx = !badStop;
    repeat (BAUD_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (BAUD_DIV) @(negedge clk);
  endtask
  task automatic send_frame(input int badIdx);
    gotA.delete();
    gotD.delete();
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], i == badIdx);
      if (i == badIdx) break;
    end
    repeat (10) @(negedge clk);
  endtask
  task automatic add_csum(input bit corrupt);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 2; i < fr.size(); i++) s = s + fr[i];
    fr.push_back(s + 8'(corrupt));
  endtask
  task automatic model(input int badIdx);
    int n, sum;
    expA.delete();
    expD.delete();
    expErr = 1'b1;
    n = int'(fr[1]);
    if (n == 0 || n > (1 << ADDR_W)) return;
    sum = 0;
    for (int i = 0; i < 4 * n; i++) sum += int'(fr[2 + i]);
    for (int w = 0; w < n; w++)
      if (badIdx < 0 || badIdx > 5 + 4 * w) begin
        expA.push_back(ADDR_W'(w));
        expD.push_back({fr[5 + 4 * w], fr[4 + 4 * w], fr[3 + 4 * w], fr[2 + 4 * w]});
      end
    expErr = badIdx >= 0 || fr[2 + 4 * n] != 8'(sum);
  endtask
  task automatic load_example(input bit corrupt);
    fr = '{8'hA5, 8'h02, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
    add_csum(corrupt);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    #2;
    total++;
    if ({imWe, imAddr, imWData, cpuRst_n, busy, err} !== '0) $display("FAIL reset_hold: outputs %h required 0", {imWe, imAddr, imWData, cpuRst_n, busy, err});
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cpuRst_n !== 1'b1) $display("FAIL reset_release_cpu: cpuRst_n %b required 1", cpuRst_n);
    else passed++;
    total++;
    if ({imWe, busy, err} !== 3'b000) $display("FAIL reset_release_flags: imWe/busy/err %b required 000", {imWe, busy, err});
    else passed++;
  endtask
  task automatic test_good_frame();
    do_reset();
    load_example(1'b0);
    model(-1);
    send_frame(-1);
    total++;
    if (gotA.size() != expA.size()) $display("FAIL good_wcount: %0d writes, required %0d", gotA.size(), expA.size());
    else passed++;
    foreach (expA[i]) if (i < gotA.size()) begin
      total++;
      if (gotA[i] !== expA[i] || gotD[i] !== expD[i]) $display("FAIL good_write%0d: %0d:%h required %0d:%h", i, gotA[i], gotD[i], expA[i], expD[i]);
      else passed++;
    end
    total++;
    if ({err, cpuRst_n, busy} !== {expErr, !expErr, 1'b0}) $display("FAIL good_status: err/cpuRst_n/busy %b required %b", {err, cpuRst_n, busy}, {expErr, !expErr, 1'b0});
    else passed++;
  endtask
  task automatic test_bad_csum();
    do_reset();
    load_example(1'b1);
    model(-1);
    send_frame(-1);
    total++;
    if (gotA.size() != expA.size()) $display("FAIL badcsum_wcount: %0d writes, required %0d", gotA.size(), expA.size());
    else passed++;
    foreach (expA[i]) if (i < gotA.size()) begin
      total++;
      if (gotA[i] !== expA[i] || gotD[i] !== expD[i]) $display("FAIL badcsum_write%0d: %0d:%h required %0d:%h", i, gotA[i], gotD[i], expA[i], expD[i]);
      else passed++;
    end
    total++;
    if ({err, cpuRst_n, busy} !== {expErr, !expErr, 1'b0}) $display("FAIL badcsum_status: err/cpuRst_n/busy %b required %b", {err, cpuRst_n, busy}, {expErr, !expErr, 1'b0});
    else passed++;
  endtask
  task automatic test_illegal_n();
    logic [7:0] counts[2];
    counts[0] = 8'h00;
    counts[1] = 8'h41;
    do_reset();
    foreach (counts[k]) begin
      fr = '{8'hA5, counts[k]};
      model(-1);
      send_frame(-1);
      total++;
      if (gotA.size() != 0 || {err, cpuRst_n, busy} !== {expErr, !expErr, 1'b0})
        $display("FAIL illegal_n_%h: writes %0d err/cpuRst_n/busy %b required 0 writes %b", counts[k], gotA.size(), {err, cpuRst_n, busy}, {expErr, !expErr, 1'b0});
      else passed++;
    end
  endtask
  task automatic test_max_count();
    do_reset();
    fr = '{8'hA5, 8'd64};
    for (int i = 0; i < 256; i++) fr.push_back(8'($urandom));
    add_csum(1'b0);
    model(-1);
    send_frame(-1);
    total++;
    if (gotA.size() != expA.size()) $display("FAIL max_wcount: %0d writes, required %0d", gotA.size(), expA.size());
    else passed++;
    foreach (expA[i]) if (i < gotA.size()) begin
      total++;
      if (gotA[i] !== expA[i] || gotD[i] !== expD[i]) $display("FAIL max_write%0d: %0d:%h required %0d:%h", i, gotA[i], gotD[i], expA[i], expD[i]);
      else passed++;
    end
    total++;
    if ({err, cpuRst_n, busy} !== {expErr, !expErr, 1'b0}) $display("FAIL max_status: err/cpuRst_n/busy %b required %b", {err, cpuRst_n, busy}, {expErr, !expErr, 1'b0});
    else passed++;
  endtask
  task automatic test_stop_err();
    do_reset();
    load_example(1'b0);
    model(4);
    send_frame(4);
    total++;
    if (gotA.size() != expA.size() || {err, cpuRst_n, busy} !== {expErr, !expErr, 1'b0})
      $display("FAIL stop_err: writes %0d err/cpuRst_n/busy %b required %0d writes %b", gotA.size(), {err, cpuRst_n, busy}, expA.size(), {expErr, !expErr, 1'b0});
    else passed++;
    model(-1);
    send_frame(-1);
    total++;
    if (gotA.size() != expA.size() || {err, cpuRst_n, busy} !== {expErr, !expErr, 1'b0})
      $display("FAIL stop_recover: writes %0d err/cpuRst_n/busy %b required %0d writes %b", gotA.size(), {err, cpuRst_n, busy}, expA.size(), {expErr, !expErr, 1'b0});
    else passed++;
  endtask
  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    total++;
    if ({busy, cpuRst_n, err} !== 3'b100) $display("FAIL timeout_midframe: busy/cpuRst_n/err %b required 100", {busy, cpuRst_n, err});
    else passed++;
    repeat (250) @(negedge clk);
    total++;
    if ({busy, cpuRst_n, err} !== 3'b001 || gotA.size() != 0) $display("FAIL timeout_err: busy/cpuRst_n/err %b writes %0d required 001 and 0 writes", {busy, cpuRst_n, err}, gotA.size());
    else passed++;
  endtask
  task automatic test_random();
    int n;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 4);
      fr = '{8'hA5, 8'(n)};
      for (int i = 0; i < 4 * n; i++) fr.push_back($urandom_range(0, 3) == 0 ? 8'hA5 : 8'($urandom));
      add_csum(1'($urandom_range(0, 1)));
      model(-1);
      send_frame(-1);
      total++;
      if (gotA.size() != expA.size()) $display("FAIL rand%0d_wcount: %0d writes, required %0d", f, gotA.size(), expA.size());
      else passed++;
      foreach (expA[i]) if (i < gotA.size()) begin
        total++;
        if (gotA[i] !== expA[i] || gotD[i] !== expD[i]) $display("FAIL rand%0d_write%0d: %0d:%h required %0d:%h", f, i, gotA[i], gotD[i], expA[i], expD[i]);
        else passed++;
      end
      total++;
      if ({err, cpuRst_n, busy} !== {expErr, !expErr, 1'b0}) $display("FAIL rand%0d_status: err/cpuRst_n/busy %b required %b", f, {err, cpuRst_n, busy}, {expErr, !expErr, 1'b0});
      else passed++;
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    load_example(1'b0);
    for (int i = 0; i < 7; i++) send_byte(fr[i], 1'b0);
    total++;
    if ({busy, imAddr} !== {1'b1, ADDR_W'(1)} || imWData !== 32'h00100513) $display("FAIL arst_pre: busy %b imAddr %0d imWData %h required 1 1 00100513", busy, imAddr, imWData);
    else passed++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({imWe, imAddr, imWData, cpuRst_n, busy, err} !== '0) $display("FAIL arst_outputs: %h required 0", {imWe, imAddr, imWData, cpuRst_n, busy, err});
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({cpuRst_n, busy, err} !== 3'b100) $display("FAIL arst_release: cpuRst_n/busy/err %b required 100", {cpuRst_n, busy, err});
    else passed++;
  endtask
  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_illegal_n();
    test_stop_err();
    test_timeout();
    test_random();
    test_max_count();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
